fmc_adc_ext_trig_cond: RTL and testbench

- Conditions the external trigger input of the FMC-ADC mezzanine before it reaches the acquisition trigger logic.
- Processing chain: asynchronous synchroniser, polarity selection, glitch filter, rising-edge detection, programmable delay.
- Output is a single-cycle trigger pulse in the ADC sampling clock domain.
- Sits between the ext-trigger LVDS input buffer and the trigger-source OR / acquisition FSM in the ADC core; configured from the CSR (EXT_TRIG_DLY, trigger enable/polarity).

---
 rtl/fmc_adc_ext_trig_cond.sv | 169 ++++++++++++++++
 tb/tb_fmc_adc_ext_trig_cond.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmc_adc_ext_trig_cond.sv
`default_nettype none
// ============================================================================
// fmc_adc_ext_trig_cond : FMC-ADC external trigger conditioner. It synchronises
//   the input, applies polarity and a glitch filter, detects the edge and adds a
//   programmable delay. FMC_ADC_EXT_TRIG_CNT_EN adds trigger/miss counters.
// Revision : 1.0
// ============================================================================
module fmc_adc_ext_trig_cond #(
  parameter int g_SYNC_STAGES = 2,
  parameter int g_DLY_WIDTH   = 32,
  parameter int g_FLT_WIDTH   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   ext_trig_a_i,
  input  logic                   en_i,
  input  logic                   pol_i,
  input  logic [g_FLT_WIDTH-1:0] glitch_len_i,
  input  logic [g_DLY_WIDTH-1:0] dly_i,
  output logic                   trig_p_o,
  output logic                   busy_o,
  output logic                   missed_p_o,
  output logic                   level_o
`ifdef FMC_ADC_EXT_TRIG_CNT_EN
  ,
  output logic [31:0]            trig_cnt_o,
  output logic [31:0]            miss_cnt_o
`endif
);

  localparam logic [g_FLT_WIDTH-1:0] c_FLT_ONE = {{(g_FLT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [g_DLY_WIDTH-1:0] c_DLY_ONE = {{(g_DLY_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DELAY = 1'b1
  } state_t;

  logic [g_SYNC_STAGES-1:0] r_sync;
  logic                     w_sync_s;
  logic                     r_flt;
  logic [g_FLT_WIDTH-1:0]   r_fcnt;
  logic                     r_flt_d;
  logic                     r_edge;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [g_DLY_WIDTH-1:0]   r_dcnt;
  logic [g_DLY_WIDTH-1:0]   w_dcnt_nxt;
  logic                     r_trig;
  logic                     w_trig_nxt;
  logic                     r_missed;
  logic                     w_missed_nxt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[g_SYNC_STAGES-2:0], ext_trig_a_i};
    end
  end

  assign w_sync_s = r_sync[g_SYNC_STAGES-1] ^ pol_i;

  // A new level is accepted only after it has differed from r_flt for
  // glitch_len_i+1 consecutive cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_flt  <= 1'b0;
      r_fcnt <= '0;
    end else if (w_sync_s == r_flt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == glitch_len_i) begin
      r_flt  <= w_sync_s;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + c_FLT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_flt_d <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_flt_d <= r_flt;
      r_edge  <= r_flt & ~r_flt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_dcnt   <= '0;
      r_trig   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_trig   <= w_trig_nxt;
      r_missed <= w_missed_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    w_trig_nxt   = 1'b0;
    w_missed_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_edge && en_i) begin
          if (dly_i == '0) begin
            w_trig_nxt = 1'b1;
          end else begin
            w_dcnt_nxt  = dly_i - c_DLY_ONE;
            w_state_nxt = ST_DELAY;
          end
        end
      end
      ST_DELAY: begin
        // Disabling mid-delay drops the pending trigger silently.
        if (!en_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_missed_nxt = r_edge;
          if (r_dcnt == '0) begin
            w_trig_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_dcnt_nxt = r_dcnt - c_DLY_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign trig_p_o   = r_trig;
  assign missed_p_o = r_missed;
  assign busy_o     = (r_state == ST_DELAY);
  assign level_o    = r_flt;

`ifdef FMC_ADC_EXT_TRIG_CNT_EN
  logic [31:0] r_trig_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || !en_i) begin
      r_trig_cnt <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else begin
      if (r_trig) begin
        r_trig_cnt <= r_trig_cnt + 32'd1;
      end
      if (r_missed) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign trig_cnt_o = r_trig_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fmc_adc_ext_trig_cond.sv
`default_nettype none
// ============================================================================
// tb_fmc_adc_ext_trig_cond : scoreboard bench for fmc_adc_ext_trig_cond.
// Revision : 1.0
// ============================================================================
module tb_fmc_adc_ext_trig_cond;

  localparam int SYNC_STAGES = 2;
  localparam int DLY_WIDTH   = 32;
  localparam int FLT_WIDTH   = 8;

  logic                 clk_125m_pllref = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ext   = 1'b0;
  logic                 en    = 1'b0;
  logic                 pol   = 1'b0;
  logic [FLT_WIDTH-1:0] glitch_len = '0;
  logic [DLY_WIDTH-1:0] dly = '0;
  logic                 trig_p;
  logic                 busy;
  logic                 missed_p;
  logic                 level;
`ifdef FMC_ADC_EXT_TRIG_CNT_EN
  logic [31:0]          trig_cnt;
  logic [31:0]          miss_cnt;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int lvl_cnt = 0;
  int busy_cnt = 0;
  int t0;
  int trig_q[$];
  int miss_q[$];

  fmc_adc_ext_trig_cond #(
    .g_SYNC_STAGES(SYNC_STAGES),
    .g_DLY_WIDTH  (DLY_WIDTH),
    .g_FLT_WIDTH  (FLT_WIDTH)
  ) dut (
    .clk_i       (clk_125m_pllref),
    .rst_n_i     (rst_n),
    .ext_trig_a_i(ext),
    .en_i        (en),
    .pol_i       (pol),
    .glitch_len_i(glitch_len),
    .dly_i       (dly),
    .trig_p_o    (trig_p),
    .busy_o      (busy),
    .missed_p_o  (missed_p),
    .level_o     (level)
`ifdef FMC_ADC_EXT_TRIG_CNT_EN
    ,
    .trig_cnt_o  (trig_cnt),
    .miss_cnt_o  (miss_cnt)
`endif
  );

  always #5 clk_125m_pllref = ~clk_125m_pllref;
  always @(posedge clk_125m_pllref) cyc <= cyc + 1;

  // Every output pulse must match the cycle stamp expected at the queue head.
  always @(negedge clk_125m_pllref) begin
    if (rst_n) begin
      if (trig_p) begin
        checks++;
        if (trig_q.size() == 0) begin
          errors++;
          $display("FAIL trig_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          int exp_c;
          exp_c = trig_q.pop_front();
          if (exp_c != cyc) begin
            errors++;
            $display("FAIL trig_cycle: pulse at cycle %0d, expected %0d", cyc, exp_c);
          end
        end
      end
      if (missed_p) begin
        checks++;
        if (miss_q.size() == 0) begin
          errors++;
          $display("FAIL missed_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          int exp_c;
          exp_c = miss_q.pop_front();
          if (exp_c != cyc) begin
            errors++;
            $display("FAIL missed_cycle: pulse at cycle %0d, expected %0d", cyc, exp_c);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_125m_pllref);
      if (level) lvl_cnt++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic drain(input string name);
    checks++;
    if (trig_q.size() != 0 || miss_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d trig and %0d missed pulses never seen",
               name, trig_q.size(), miss_q.size());
      trig_q.delete();
      miss_q.delete();
    end
  endtask

  // Active level of the raw input depends on the selected polarity.
  task automatic pulse(input int len);
    ext = ~pol;
    tick(len);
    ext = pol;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("reset_trig", {31'd0, trig_p}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_missed", {31'd0, missed_p}, 32'd0);
    chk("reset_level", {31'd0, level}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    // Plain rising edge, no filter, no delay.
    en = 1'b1;
    tick(2);
    lvl_cnt = 0;
    t0 = cyc + 1;
    trig_q.push_back(t0 + 4);
    pulse(10);
    tick(15);
    chk("A_level_len", lvl_cnt, 32'd10);
    drain("A");

    // Glitch filter of length 3: short pulses are swallowed.
    en = 1'b0;
    glitch_len = 8'd3;
    tick(5);
    en = 1'b1;
    tick(2);
    lvl_cnt = 0;
    pulse(1); tick(1);
    pulse(1); tick(1);
    pulse(3); tick(5);
    chk("B_short_level", lvl_cnt, 32'd0);
    lvl_cnt = 0;
    t0 = cyc + 1;
    trig_q.push_back(t0 + 7);
    pulse(12);
    tick(25);
    chk("B_level_len", lvl_cnt, 32'd12);
    drain("B");

    // Delay of 3 cycles.
    en = 1'b0;
    glitch_len = 8'd0;
    dly = 32'd3;
    tick(3);
    en = 1'b1;
    tick(2);
    busy_cnt = 0;
    t0 = cyc + 1;
    trig_q.push_back(t0 + 7);
    pulse(5);
    tick(15);
    chk("C_busy_len", busy_cnt, 32'd3);
    drain("C1");

    // Second edge lands on the exit cycle of the delay.
    t0 = cyc + 1;
    trig_q.push_back(t0 + 7);
    miss_q.push_back(t0 + 7);
    pulse(2); tick(1);
    pulse(3);
    tick(15);
    drain("C2");

    // Inverted polarity; the edge created while disabled is discarded.
    en = 1'b0;
    dly = 32'd0;
    ext = 1'b1;
    tick(4);
    pol = 1'b1;
    tick(4);
    chk("D_idle_level", {31'd0, level}, 32'd0);
    en = 1'b1;
    tick(2);
    lvl_cnt = 0;
    t0 = cyc + 1;
    trig_q.push_back(t0 + 4);
    pulse(6);
    tick(15);
    chk("D_level_len", lvl_cnt, 32'd6);
    drain("D");
    en = 1'b0;
    pol = 1'b0;
    ext = 1'b0;
    tick(6);

    // Long delay aborted by reset.
    en = 1'b1;
    dly = 32'd100;
    tick(2);
    t0 = cyc + 1;
    pulse(3);
    tick(t0 + 44 - cyc);
    chk("E1_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("E1_busy_after", {31'd0, busy}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(120);
    drain("E1");

    // Long delay aborted by disabling.
    tick(2);
    t0 = cyc + 1;
    pulse(3);
    tick(t0 + 44 - cyc);
    chk("E2_busy_before", {31'd0, busy}, 32'd1);
    en = 1'b0;
    tick(1);
    chk("E2_busy_after", {31'd0, busy}, 32'd0);
    en = 1'b1;
    tick(120);
    drain("E2");

`ifdef FMC_ADC_EXT_TRIG_CNT_EN
    en = 1'b0;
    dly = 32'd3;
    tick(2);
    en = 1'b1;
    tick(2);
    repeat (2) begin
      t0 = cyc + 1;
      trig_q.push_back(t0 + 7);
      miss_q.push_back(t0 + 7);
      pulse(2); tick(1);
      pulse(3);
      tick(15);
    end
    t0 = cyc + 1;
    trig_q.push_back(t0 + 7);
    pulse(5);
    tick(15);
    drain("F");
    chk("F_trig_cnt", trig_cnt, 32'd3);
    chk("F_miss_cnt", miss_cnt, 32'd2);
    en = 1'b0;
    tick(1);
    chk("F_trig_cnt_clr", trig_cnt, 32'd0);
    chk("F_miss_cnt_clr", miss_cnt, 32'd0);
    en = 1'b1;
    tick(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
